// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipe elastic register pipeline.
//
// Contents:
//   DEFAULT_WIDTH  default data width of one pipeline stage
//   DEFAULT_DEPTH  default number of pipeline stages
//   occ_w(depth)   width of an occupancy counter that can hold 0..depth
package dff_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // The occupancy counter must represent DEPTH itself, so it needs
  // clog2(DEPTH+1) bits rather than clog2(DEPTH). DEPTH=1 therefore gives 1 bit.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One stage of the dff_pipe elastic pipeline: a valid flop plus a WIDTH-bit
// data flop. The parent computes the handshake chain; this stage only
// applies it.
//
// Configuration macro: DFF_PIPE_DATA_RST_EN
//   defined   : the data flop is reset to RESET_VAL together with the valid bit
//   undefined : the data flop has no reset; only the valid bit is reset
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous reset, active-low
//   take   in   1      stage loads in_v/in_d on this edge
//   leave  in   1      stage's word moves on (downstream or out) this edge
//   clear  in   1      flush request (already qualified with enable)
//   in_v   in   1      valid bit from the upstream stage (or in_valid)
//   in_d   in   WIDTH  data from the upstream stage (or in_data)
//   v      out  1      registered valid bit
//   d      out  WIDTH  registered data word
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             take,
  input  logic             leave,
  input  logic             clear,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             v_d;
  logic             v_q;
  logic [WIDTH-1:0] d_d;
  logic [WIDTH-1:0] d_q;

  // take has priority: a stage that is being emptied and refilled on the
  // same edge simply loads the new word. take is never asserted together
  // with clear because the parent gates take with ~flush.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (take) begin
      v_d = in_v;
      d_d = in_d;
    end else if (leave || clear) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end

`ifdef DFF_PIPE_DATA_RST_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q <= RESET_VAL;
    end else begin
      d_q <= d_d;
    end
  end
`else
  // Data flops deliberately carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    d_q <= d_d;
  end
`endif

  assign v = v_q;
  assign d = d_q;

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: parametrised elastic register pipeline of DEPTH stages, each a
// WIDTH-bit data flop with a valid bit. Used as a timing break / retiming
// chain between a producer and a consumer, with stall, bubble collapsing,
// flush and an occupancy count.
//
// Configuration macro: DFF_PIPE_DATA_RST_EN
//   defined   : reset also loads every data flop with RESET_VAL
//   undefined : data flops are not reset; out_data is unknown until first load
//
// Ports:
//   clk        in   1                clock, all state updates on posedge
//   rst        in   1                synchronous reset, active-low
//   en         in   1                global enable; 0 freezes all state
//   flush      in   1                synchronous clear of every valid bit
//   in_valid   in   1                producer offers in_data
//   in_ready   out  1                pipe accepts in_data this cycle
//   in_data    in   WIDTH            input word
//   out_valid  out  1                last stage holds a word
//   out_ready  in   1                consumer accepts out_data
//   out_data   out  WIDTH            last stage data
//   occupancy  out  clog2(DEPTH+1)   number of valid stages
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 in the preceding cycle. in_ready is combinational from out_ready,
// en, flush and the stage valid bits; it does not depend on in_valid.
// out_valid/out_data come straight from the last stage's flops and do not
// depend on out_ready.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_w(DEPTH);

  // Stage state and per-stage handshake terms.
  logic [DEPTH-1:0] v_vec;
  logic [DEPTH-1:0] take;
  logic [DEPTH-1:0] leave;
  logic [DEPTH-1:0] stage_in_v;
  logic [WIDTH-1:0] stage_in_d [DEPTH];
  logic [WIDTH-1:0] d_arr      [DEPTH];

  // Reset dominates enable: folding rst into the enable keeps in_ready low
  // during the reset cycle and stops any fire from being reported then.
  logic live;
  logic clear;

  assign live  = en & rst;
  assign clear = live & flush;

  // Ready chain, evaluated from the output side back to the input side.
  // A stage can take a word when it is empty or when its own word leaves on
  // the same edge. Because an empty stage can always take, a word advances
  // into any downstream hole even while out_ready is low (bubble collapse).
  // The output handshake is not gated by flush, so a word presented with
  // out_ready=1 during a flush is still delivered.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == DEPTH - 1) begin : g_last
      assign leave[i] = live & v_vec[i] & out_ready;
    end else begin : g_mid
      assign leave[i] = v_vec[i] & take[i+1];
    end

    assign take[i] = live & ~flush & (~v_vec[i] | leave[i]);

    if (i == 0) begin : g_head
      assign stage_in_v[i] = in_valid;
      assign stage_in_d[i] = in_data;
    end else begin : g_body
      assign stage_in_v[i] = v_vec[i-1];
      assign stage_in_d[i] = d_arr[i-1];
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .take  (take[i]),
      .leave (leave[i]),
      .clear (clear),
      .in_v  (stage_in_v[i]),
      .in_d  (stage_in_d[i]),
      .v     (v_vec[i]),
      .d     (d_arr[i])
    );
  end

  assign in_ready  = take[0];
  assign out_valid = v_vec[DEPTH-1];
  assign out_data  = d_arr[DEPTH-1];

  // Occupancy is a popcount of the registered valid bits.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(v_vec[i]);
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  always #5 clk = ~clk;

  dff_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL ('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
  endtask

  task automatic wait_empty(input string tag);
    logic done;
    done = 1'b0;
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (occupancy == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(done), 32'd1);
    tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  // Sampled on the falling edge: the values seen here are what the next
  // rising edge will act on.
  always @(negedge clk) begin
    logic [WIDTH-1:0] front;
    if (rst === 1'b1) begin
      chk("occ_vs_model", 32'(occupancy), 32'(exp_q.size()));
      if (en && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_underflow", 32'd1, 32'd0);
        end else begin
          front = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(front));
        end
      end
      if (en && flush) begin
        exp_q.delete();
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
      end
    end else begin
      exp_q.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int first_k;
    int out_cnt;
    int acc;

    rst = 1'b0; en = 1'b1; flush = 1'b0;
    drive(1'b0, '0, 1'b0);

    // 1. reset
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef DFF_PIPE_DATA_RST_EN
    chk("rst_out_data", 32'(out_data), 32'd0);
`endif
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // 2. streaming with out_ready=1: latency DEPTH, then one word per cycle
    first_k = -1;
    out_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      drive(k < 16, WIDTH'(k + 1), 1'b1);
      @(negedge clk);
      if (k < 16) chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin
        out_cnt++;
        if (first_k < 0) first_k = k;
      end
      tick();
    end
    chk("stream_latency", 32'(first_k), 32'(DEPTH));
    chk("stream_out_count", 32'(out_cnt), 32'd16);
    wait_empty("stream_drain");

    // 3. stalled output: 4 of 6 offered words accepted
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, WIDTH'(8'h20 + k), 1'b0);
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("stall_accepted", 32'(acc), 32'(DEPTH));
    chk("stall_occupancy", 32'(occupancy), 32'(DEPTH));
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    tick();
    wait_empty("stall_drain");

    // 4. full pipe with simultaneous in/out fire
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, WIDTH'(8'h30 + k), 1'b0);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, WIDTH'(8'h34 + k), 1'b1);
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd1);
      chk("full_occupancy", 32'(occupancy), 32'(DEPTH));
      chk("full_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    wait_empty("full_drain");

    // 5. gapped input with output stalled: words pack at the output end
    drive(1'b1, 8'h40, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    drive(1'b1, 8'h41, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    chk("gap_occupancy", 32'(occupancy), 32'd2);
    chk("gap_out_valid", 32'(out_valid), 32'd1);
    chk("gap_out_data", 32'(out_data), 32'h40);
    chk("gap_in_ready", 32'(in_ready), 32'd1);
    tick();
    wait_empty("gap_drain");

    // 6. freeze with en=0, flush gated by en, then a real flush
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, WIDTH'(8'h50 + k), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    tick();
    en = 1'b0;
    drive(1'b1, 8'h53, 1'b1);
    for (int k = 0; k < 3; k++) begin
      flush = (k == 2);
      @(negedge clk);
      chk("freeze_in_ready", 32'(in_ready), 32'd0);
      chk("freeze_occupancy", 32'(occupancy), 32'd3);
      chk("freeze_out_valid", 32'(out_valid), 32'd1);
      chk("freeze_out_data", 32'(out_data), 32'h50);
      tick();
    end
    en = 1'b1;
    flush = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("flush_occupancy", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    tick();

    // post-flush traffic still flows in order
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, WIDTH'(8'h60 + k), 1'b1);
      tick();
    end
    wait_empty("final_drain");
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
